// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg
// Shared definitions for the RISC-V control units.
//   - state_t   : multi-cycle sequencer state encoding (also seen on state_o)
//   - OP_*      : 7-bit major opcodes understood by the decoder
//   - ALUOP_*   : 2-bit ALU control class handed to the ALU decoder
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b101
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_LUI    = 7'h37;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

endpackage

// File: rtl/rv_opcode_decode.sv
// rv_opcode_decode
// Combinational map from an opcode to instruction-class flags and the ALU
// control class. Shared by the single-cycle and multi-cycle control units.
// Ports:
//   opcode    in  OPCODE_W  opcode to classify (only 7 is meaningful)
//   is_load   out 1         0x03
//   is_store  out 1         0x23
//   is_branch out 1         0x63
//   is_jal    out 1         0x6F
//   legal     out 1         one of the seven supported opcodes
//   alusrc    out 1         ALU operand B is the immediate
//   aluop     out 2         ALU control class
module rv_opcode_decode
  import rv_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic                is_load,
  output logic                is_store,
  output logic                is_branch,
  output logic                is_jal,
  output logic                legal,
  output logic                alusrc,
  output logic [1:0]          aluop
);

  logic is_rtype;
  logic is_itype;
  logic is_lui;

  always_comb begin
    is_rtype  = (opcode == OP_RTYPE);
    is_itype  = (opcode == OP_ITYPE);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_branch = (opcode == OP_BRANCH);
    is_jal    = (opcode == OP_JAL);
    is_lui    = (opcode == OP_LUI);
    legal     = is_rtype | is_itype | is_load | is_store | is_branch | is_jal | is_lui;
    // LUI uses the immediate path so the datapath can pass it through the ALU.
    alusrc    = is_itype | is_load | is_store | is_lui;
    if (is_rtype)       aluop = ALUOP_RFUNCT;
    else if (is_itype)  aluop = ALUOP_IFUNCT;
    else if (is_branch) aluop = ALUOP_SUB;
    else                aluop = ALUOP_ADD;
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl
// Multi-cycle RISC-V control sequencer: FETCH -> DECODE -> EXEC -> [MEM] ->
// [WB], with a ready-based memory handshake, a global stall and a sticky
// illegal-opcode trap.
// Optional feature: define CTRL_PERF_CNT_EN to add cycle_cnt / instr_cnt.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   opcode            opcode from memory read data, latched on ir_we
//   mem_ready         memory finished the current fetch/load/store
//   stall             freeze the sequencer and suppress all write strobes
//   ir_we, pc_we      instruction register / PC write strobes
//   regwr, mw         register-file / data-memory write strobes
//   br, jump, memreg, mr, alusrc, aluop   datapath control levels
//   illegal           sticky trap flag
//   state_o           current state, for debug
//   cycle_cnt, instr_cnt  (CTRL_PERF_CNT_EN only) free-running counters
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int ALUOP_W  = 2
`ifdef CTRL_PERF_CNT_EN
  ,
  parameter int CNT_W    = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                stall,
  output logic                ir_we,
  output logic                pc_we,
  output logic                br,
  output logic                jump,
  output logic                memreg,
  output logic                mr,
  output logic                mw,
  output logic                alusrc,
  output logic                regwr,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                illegal,
  output logic [2:0]          state_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt
`endif
);

  state_t              state_reg;
  logic [OPCODE_W-1:0] opcode_reg;

  logic       dec_load;
  logic       dec_store;
  logic       dec_branch;
  logic       dec_jal;
  logic       dec_legal;
  logic       dec_alusrc;
  logic [1:0] dec_aluop;
  logic [1:0] aluop_lo;
  logic       strobe_en;

  rv_opcode_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .opcode    (opcode_reg),
    .is_load   (dec_load),
    .is_store  (dec_store),
    .is_branch (dec_branch),
    .is_jal    (dec_jal),
    .legal     (dec_legal),
    .alusrc    (dec_alusrc),
    .aluop     (dec_aluop)
  );

  // Sequencer. stall simply withholds every state/opcode update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_FETCH;
      opcode_reg <= '0;
    end else if (!stall) begin
      case (state_reg)
        S_FETCH: begin
          if (mem_ready) begin
            opcode_reg <= opcode;
            state_reg  <= S_DECODE;
          end
        end
        S_DECODE: state_reg <= dec_legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          if (dec_branch)                 state_reg <= S_FETCH;
          else if (dec_load || dec_store) state_reg <= S_MEM;
          else                            state_reg <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) state_reg <= dec_load ? S_WB : S_FETCH;
        end
        S_WB:    state_reg <= S_FETCH;
        S_TRAP:  state_reg <= S_TRAP;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  // Outputs are decoded from state and latched opcode. Levels naturally hold
  // during stall because neither changes; strobes are masked by stall. rst is
  // folded in so every output is 0 while reset is asserted, and a store in
  // flight is withdrawn immediately when reset arrives.
  always_comb begin
    strobe_en = !stall && !rst;
    ir_we     = (state_reg == S_FETCH) && mem_ready && strobe_en;
    pc_we     = strobe_en && (((state_reg == S_EXEC) && dec_branch) ||
                              ((state_reg == S_MEM) && dec_store && mem_ready) ||
                              (state_reg == S_WB));
    regwr     = (state_reg == S_WB) && strobe_en;
    // mw stays up through wait cycles; memory commits on its mem_ready cycle.
    mw        = (state_reg == S_MEM) && dec_store && strobe_en;
    mr        = !rst && ((state_reg == S_FETCH) || ((state_reg == S_MEM) && dec_load));
    br        = (state_reg == S_EXEC) && dec_branch;
    jump      = (state_reg == S_WB) && dec_jal;
    memreg    = (state_reg == S_WB) && dec_load;
    alusrc    = (state_reg == S_EXEC) && dec_alusrc;
    aluop_lo  = (state_reg == S_EXEC) ? dec_aluop : ALUOP_ADD;
    illegal   = (state_reg == S_TRAP);
  end

  assign aluop   = ALUOP_W'(aluop_lo);
  assign state_o = state_reg;

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state_reg != S_TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (pc_we)               instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl
// Directed bench for rv_multicycle_ctrl: a table of one record per opcode
// class run with an always-ready memory, then hand-written sequences for
// reset, stall, slow memory, reset during a store and the illegal trap.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_rv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       stall;
  logic       ir_we, pc_we, br, jump, memreg, mr, mw, alusrc, regwr, illegal;
  logic [1:0] aluop;
  logic [2:0] state_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int checks     = 0;
  int failures   = 0;
  int instr_done = 0;

  always #5 clk = ~clk;

  rv_multicycle_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .stall     (stall),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .br        (br),
    .jump      (jump),
    .memreg    (memreg),
    .mr        (mr),
    .mw        (mw),
    .alusrc    (alusrc),
    .regwr     (regwr),
    .aluop     (aluop),
    .illegal   (illegal),
    .state_o   (state_o)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
`endif
  );

  typedef struct {
    logic [6:0] op;
    int lat;     // cycle (1 = FETCH) on which pc_we pulses
    int irwe;    // ir_we cycles
    int mrc;     // mr cycles
    int alusrc;  // alusrc seen in EXEC
    int aluop;   // aluop seen in EXEC
    int brc;     // br cycles
    int jumpc;   // jump cycles
    int memregc; // memreg cycles
    int regwrc;  // regwr cycles
    int mwc;     // mw cycles
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int lat, irwe_n, mr_n, br_n, jump_n, memreg_n, regwr_n, mw_n;
    logic [31:0] ex_alusrc, ex_aluop;
    lat = 0; irwe_n = 0; mr_n = 0; br_n = 0; jump_n = 0;
    memreg_n = 0; regwr_n = 0; mw_n = 0;
    ex_alusrc = 32'hFFFF_FFFF; ex_aluop = 32'hFFFF_FFFF;
    opcode = v.op; mem_ready = 1'b1; stall = 1'b0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (state_o == 3'b010) begin
        ex_alusrc = 32'(alusrc);
        ex_aluop  = 32'(aluop);
      end
      irwe_n   += int'(ir_we);
      mr_n     += int'(mr);
      br_n     += int'(br);
      jump_n   += int'(jump);
      memreg_n += int'(memreg);
      regwr_n  += int'(regwr);
      mw_n     += int'(mw);
      if (pc_we) lat = c;
      next_cycle();
    end
    opcode = 7'h00;
    check($sformatf("op%h_latency", v.op), lat, v.lat);
    check($sformatf("op%h_ir_we", v.op), irwe_n, v.irwe);
    check($sformatf("op%h_mr", v.op), mr_n, v.mrc);
    check($sformatf("op%h_alusrc", v.op), ex_alusrc, v.alusrc);
    check($sformatf("op%h_aluop", v.op), ex_aluop, v.aluop);
    check($sformatf("op%h_br", v.op), br_n, v.brc);
    check($sformatf("op%h_jump", v.op), jump_n, v.jumpc);
    check($sformatf("op%h_memreg", v.op), memreg_n, v.memregc);
    check($sformatf("op%h_regwr", v.op), regwr_n, v.regwrc);
    check($sformatf("op%h_mw", v.op), mw_n, v.mwc);
    check($sformatf("op%h_back_to_fetch", v.op), state_o, 3'b000);
    instr_done++;
`ifdef CTRL_PERF_CNT_EN
    check($sformatf("op%h_instr_cnt", v.op), instr_cnt, instr_done);
`endif
    $display("vec op=%h latency=%0d aluop=%0d alusrc=%0d regwr=%0d mw=%0d",
             v.op, lat, ex_aluop, ex_alusrc, regwr_n, mw_n);
  endtask

  initial begin
    int lat, regwr_n, bad, mw_held;
    logic [31:0] memreg_wb;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cc0, ic0;
`endif

    //            op     lat irwe mr src aluop br jmp mreg rw mw
    vecs[0] = '{7'h33, 4,  1,   1, 0,  2,    0, 0,  0,   1, 0};
    vecs[1] = '{7'h13, 4,  1,   1, 1,  3,    0, 0,  0,   1, 0};
    vecs[2] = '{7'h03, 5,  1,   2, 1,  0,    0, 0,  1,   1, 0};
    vecs[3] = '{7'h23, 4,  1,   1, 1,  0,    0, 0,  0,   0, 1};
    vecs[4] = '{7'h63, 3,  1,   1, 0,  1,    1, 0,  0,   0, 0};
    vecs[5] = '{7'h6F, 4,  1,   1, 0,  0,    0, 1,  0,   1, 0};
    vecs[6] = '{7'h37, 4,  1,   1, 1,  0,    0, 0,  0,   1, 0};

    // Reset: everything 0, even with memory claiming ready.
    rst = 1'b1; opcode = 7'h33; mem_ready = 1'b1; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state_o, 3'b000);
    check("rst_mr", mr, 1'b0);
    check("rst_ir_we", ir_we, 1'b0);
    check("rst_pc_we", pc_we, 1'b0);
    check("rst_illegal", illegal, 1'b0);
`ifdef CTRL_PERF_CNT_EN
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
`endif
    rst = 1'b0;
    #1;
    check("fetch_mr_after_rst", mr, 1'b1);
    $display("reset sequence done");

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Stall in WB of an I-type: two frozen cycles, then exactly one write.
    opcode = 7'h13; mem_ready = 1'b1;
    lat = 0; regwr_n = 0; bad = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      stall = (c == 4 || c == 5);
      @(negedge clk);
      if (c == 4 || c == 5)
        if (regwr || pc_we || state_o != 3'b100) bad++;
      regwr_n += int'(regwr);
      if (pc_we) lat = c;
      next_cycle();
    end
    stall = 1'b0;
    check("stall_wb_frozen", bad, 0);
    check("stall_wb_latency", lat, 6);
    check("stall_wb_regwr_once", regwr_n, 1);
    instr_done++;
    $display("stall-in-WB sequence latency=%0d", lat);

    // Load with memory not ready for three MEM cycles.
    opcode = 7'h03;
    lat = 0; regwr_n = 0; bad = 0; memreg_wb = 32'hFFFF_FFFF;
    for (int c = 1; c <= 14 && lat == 0; c++) begin
      mem_ready = (c == 1 || c >= 7);
      @(negedge clk);
      if (c >= 4 && c <= 6)
        if (state_o != 3'b011 || !mr || regwr || pc_we) bad++;
      regwr_n += int'(regwr);
      if (pc_we) begin
        lat = c;
        memreg_wb = 32'(memreg);
      end
      next_cycle();
    end
    check("slow_load_wait", bad, 0);
    check("slow_load_latency", lat, 8);
    check("slow_load_memreg", memreg_wb, 1);
    check("slow_load_regwr", regwr_n, 1);
    instr_done++;
    $display("slow load sequence latency=%0d", lat);

    // Stall in FETCH: mr level held, no ir_we, state held; then a branch.
    opcode = 7'h33; mem_ready = 1'b1; stall = 1'b1;
    @(negedge clk);
    check("stall_fetch_mr", mr, 1'b1);
    check("stall_fetch_ir_we", ir_we, 1'b0);
    next_cycle();
    check("stall_fetch_state", state_o, 3'b000);
    stall = 1'b0;
    $display("stall-in-FETCH sequence done");
    run_vec(vecs[4]);

    // Store stuck in MEM, then reset arrives mid-cycle.
    opcode = 7'h23; mw_held = 0;
    for (int c = 1; c <= 5; c++) begin
      mem_ready = (c == 1);
      @(negedge clk);
      if (c >= 4) mw_held += int'(mw && !pc_we);
      if (c < 5) next_cycle();
    end
    check("store_wait_mw_held", mw_held, 2);
    check("store_wait_state", state_o, 3'b011);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_store_mw", mw, 1'b0);
    check("rst_mid_store_state", state_o, 3'b000);
    check("rst_mid_store_illegal", illegal, 1'b0);
    check("rst_mid_store_pc_we", pc_we, 1'b0);
`ifdef CTRL_PERF_CNT_EN
    check("rst_mid_store_instr_cnt", instr_cnt, 32'd0);
`endif
    next_cycle();
    rst = 1'b0;
    instr_done = 0;
    $display("reset-during-store sequence done");

    // Illegal opcode: trap from cycle 3 on, nothing written for 20 cycles.
    opcode = 7'h7F; mem_ready = 1'b1; bad = 0;
`ifdef CTRL_PERF_CNT_EN
    cc0 = '0; ic0 = '0;
`endif
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 2) check("illegal_decode_flag", illegal, 1'b0);
      if (c >= 3)
        if (!illegal || ir_we || pc_we || regwr || mw || state_o != 3'b101) bad++;
`ifdef CTRL_PERF_CNT_EN
      if (c == 3) begin
        cc0 = cycle_cnt;
        ic0 = instr_cnt;
      end
      if (c == 22) begin
        check("trap_cycle_cnt_frozen", cycle_cnt, cc0);
        check("trap_instr_cnt_frozen", instr_cnt, ic0);
      end
`endif
      next_cycle();
    end
    check("illegal_trap_cycles", bad, 0);
    check("illegal_state", state_o, 3'b101);
    $display("illegal opcode sequence done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Multi-cycle successor to the single-cycle combinational RISC-V control unit. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with a ready-based memory handshake and a global stall. It decodes the existing five opcode classes plus JAL and LUI, and traps on illegal opcodes. It sits between the instruction register/memory interface and the datapath (PC, register file, ALU, data memory muxes).

Parameters:
OPCODE_W, 7, opcode field width; only 7 is legal.
ALUOP_W, 2, aluop output width; must be >= 2; bits above [1:0] are driven 0.
CNT_W, 32, width of the optional performance counters.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
opcode  in  OPCODE_W  opcode field from memory read data; sampled when ir_we=1.
mem_ready  in  1  memory completed the current fetch/load/store this cycle.
stall  in  1  freeze sequencer; suppress all write strobes.
ir_we  out  1  latch instruction register (fetch completes).
pc_we  out  1  update PC; one-cycle pulse on the final cycle of every instruction.
br  out  1  branch instruction; datapath selects PC target using its zero flag.
jump  out  1  JAL: PC gets target, rd gets PC+4.
memreg  out  1  writeback source is memory data.
mr  out  1  memory read (instruction fetch or load).
mw  out  1  memory write (store).
alusrc  out  1  ALU operand B is the immediate.
regwr  out  1  register-file write.
aluop  out  ALUOP_W  00 add, 01 sub/compare, 10 R-type funct, 11 I-type funct.
illegal  out  1  sticky illegal-opcode trap flag.
state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset (async, any state): state=FETCH, latched opcode=0, illegal=0; all outputs 0 except mr, which is driven by FETCH once rst deasserts.
- Outputs are Moore-decoded from state and the latched opcode. Strobes (ir_we, pc_we, regwr, mw) are additionally gated by mem_ready where noted and always forced 0 while stall=1.
- FETCH (000): mr=1. On mem_ready=1 and stall=0: ir_we=1, latch opcode, go DECODE. Otherwise hold.
- DECODE (001): one cycle. Legal opcodes are 0x33, 0x13, 0x03, 0x23, 0x63, 0x6F, 0x37. Any other opcode -> TRAP; legal -> EXEC.
- EXEC (010): alusrc=1 for 0x13/0x03/0x23/0x37. aluop: 10 for 0x33, 11 for 0x13, 01 for 0x63, 00 otherwise.
  - 0x63: br=1, pc_we=1 -> FETCH.
  - 0x03/0x23 -> MEM.
  - All others -> WB.
- MEM (011): load asserts mr=1, store asserts mw=1, held until mem_ready.
  - Load with mem_ready -> WB.
  - Store with mem_ready: pc_we=1 -> FETCH.
  - mw is held asserted across wait cycles; the memory commits once, on the mem_ready cycle.
- WB (100): regwr=1, pc_we=1 -> FETCH. memreg=1 for 0x03; jump=1 for 0x6F.
- TRAP (101): illegal=1, all strobes 0. Stays in TRAP until rst.
- stall=1 in any state: state holds, control levels (aluop, alusrc, memreg, mr, br, jump) hold their values, strobes are 0.
- Latency with mem_ready always 1: branch 3 cycles; R/I/LUI/JAL/store 4 cycles; load 5 cycles.
- rst mid-MEM with mw=1: mw drops asynchronously; no store completes.

Optional Feature:
Macro CTRL_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt [CNT_W] and instr_cnt [CNT_W].
  - cycle_cnt increments every cycle not in TRAP.
  - instr_cnt increments on each pc_we pulse.
  - Both reset to 0 and wrap modulo 2^CNT_W.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - state encoding constants;
  - opcode constants OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI;
  - aluop constants.
- One natural sub-module: rv_opcode_decode, a combinational map from latched opcode to class flags and aluop, reused by the single-cycle unit.

Test Plan:
- Reset mid-instruction: assert rst during MEM with a store in flight -> mw=0 immediately, state_o=000, illegal=0.
- R-type, mem_ready=1: opcode 0x33 -> ir_we at cycle 1, aluop=10 and alusrc=0 in EXEC, regwr=1 and pc_we=1 at cycle 4.
- Load with slow memory: opcode 0x03, mem_ready low for 3 cycles in MEM -> mr held, then WB with regwr=1 and memreg=1; total 8 cycles.
- Store: opcode 0x23 -> mw=1 in MEM, pc_we on the mem_ready cycle, regwr never 1; branch 0x63 -> br=1, aluop=01, pc_we in EXEC, 3 cycles.
- Stall: stall=1 for 2 cycles in WB of 0x13 -> regwr=0 and state held, then regwr=1 exactly once.
- Illegal opcode 0x7F -> illegal=1 from the cycle after DECODE, all strobes 0 for 20 cycles; counters (if enabled) freeze.
